// File: rtl/flags_pkg.sv
// Shared constants for the 8086 FLAGS register: bit positions, masks,
// control-op encoding and per-flag update-enable indices.
package flags_pkg;

   localparam int unsigned FLAGS_W = 16;
   localparam int unsigned CTL_W   = 3;
   localparam int unsigned UM_W    = 6;

   localparam int unsigned CF_BIT = 0;
   localparam int unsigned PF_BIT = 2;
   localparam int unsigned AF_BIT = 4;
   localparam int unsigned ZF_BIT = 6;
   localparam int unsigned SF_BIT = 7;
   localparam int unsigned TF_BIT = 8;
   localparam int unsigned IF_BIT = 9;
   localparam int unsigned DF_BIT = 10;
   localparam int unsigned OF_BIT = 11;

   localparam logic [FLAGS_W-1:0] FLAGS_WMASK = 16'h0FD5;
   localparam logic [FLAGS_W-1:0] FLAGS_RESET = 16'hF002;

   localparam int unsigned UM_CF = 0;
   localparam int unsigned UM_PF = 1;
   localparam int unsigned UM_AF = 2;
   localparam int unsigned UM_ZF = 3;
   localparam int unsigned UM_SF = 4;
   localparam int unsigned UM_OF = 5;

   typedef enum logic [CTL_W-1:0] {
      CTL_NOP = 3'd0,
      CTL_CLC = 3'd1,
      CTL_STC = 3'd2,
      CTL_CMC = 3'd3,
      CTL_CLI = 3'd4,
      CTL_STI = 3'd5,
      CTL_CLD = 3'd6,
      CTL_STD = 3'd7
   } flag_ctl_e;

   // x86 PF: set when the low result byte holds an even number of ones
   function automatic logic even_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/flags_save_stack.sv
// LIFO of FLAGS words used to save/restore flags on interrupt entry/exit.
// Illegal requests (push+pop together, push when full, pop when empty) pulse err.
module flags_save_stack
   import flags_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [FLAGS_W-1:0] data,
   output logic [FLAGS_W-1:0] top_c,
   output logic               pop_ok_c,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty,
   output logic               err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLAGS_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]   count_nxt;
   logic [CNT_W-1:0]   top_idx;
   logic               push_ok;
   logic               err_c;

   assign push_ok  = push & ~pop & ~full;
   assign pop_ok_c = pop & ~push & ~empty;
   assign err_c    = (push & pop) | (push & full) | (pop & empty);
   assign top_idx  = count - CNT_W'(1);
   assign top_c    = mem[top_idx[PTR_W-1:0]];

   always_comb begin
      count_nxt = count;
      if (push_ok)
         count_nxt = count + CNT_W'(1);
      else if (pop_ok_c)
         count_nxt = count - CNT_W'(1);
   end

   // Storage carries no reset; contents are meaningless once count drops.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[count[PTR_W-1:0]] <= data;
   end

   // full/empty are derived from the next count so they track count exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(DEPTH));
         empty <= (count_nxt == '0);
         err   <= err_c;
      end
   end

endmodule

// File: rtl/status_flags_reg.sv
// 8086 FLAGS register: masked arithmetic updates, control-flag ops, POPF load
// and an optional save stack enabled by defining FLAGS_STACK_EN.
module status_flags_reg
   import flags_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DATA_W-1:0]                  alu_result,
   input  logic                               byte_op,
   input  logic                               carry_in,
   input  logic                               aux_carry_in,
   input  logic                               overflow_in,
   input  logic [UM_W-1:0]                    update_mask,
   input  logic [CTL_W-1:0]                   ctl_op,
   input  logic                               load_en,
   input  logic [FLAGS_W-1:0]                 load_data,
   input  logic                               push,
   input  logic                               pop,
   output logic [FLAGS_W-1:0]                 flags_out,
   output logic                               cf,
   output logic                               pf,
   output logic                               af,
   output logic                               zf,
   output logic                               sf,
   output logic                               tf,
   output logic                               if_flag,
   output logic                               df,
   output logic                               of,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               stack_err
);

   localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

   logic [FLAGS_W-1:0] flags;
   logic [FLAGS_W-1:0] flags_nxt;
   logic [FLAGS_W-1:0] arith;
   logic [FLAGS_W-1:0] stack_top;
   logic               pop_take;
   logic               byte_sel;
   logic               zf_c;
   logic               sf_c;
   flag_ctl_e          ctl;

   assign ctl      = flag_ctl_e'(ctl_op);
   assign byte_sel = byte_op | (DATA_W == 8);
   assign zf_c     = byte_sel ? (alu_result[7:0] == 8'h00) : (alu_result == '0);
   assign sf_c     = byte_sel ? alu_result[7] : alu_result[DATA_W-1];

`ifdef FLAGS_STACK_EN
   flags_save_stack #(
      .DEPTH (STACK_DEPTH),
      .CNT_W (CNT_W)
   ) u_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data     (flags),
      .top_c    (stack_top),
      .pop_ok_c (pop_take),
      .count    (stack_count),
      .full     (stack_full),
      .empty    (stack_empty),
      .err      (stack_err)
   );
`else
   logic stack_unused;

   assign stack_unused = push ^ pop;
   assign stack_top    = FLAGS_RESET;
   assign pop_take     = 1'b0;
   assign stack_count  = CNT_W'(0);
   assign stack_full   = 1'b0;
   assign stack_empty  = 1'b1;
   assign stack_err    = 1'b0;
`endif

   // Arithmetic flags first, then the control op so it overrides CF.
   always_comb begin
      arith = flags;
      if (update_mask[UM_CF]) arith[CF_BIT] = carry_in;
      if (update_mask[UM_PF]) arith[PF_BIT] = even_parity(alu_result[7:0]);
      if (update_mask[UM_AF]) arith[AF_BIT] = aux_carry_in;
      if (update_mask[UM_ZF]) arith[ZF_BIT] = zf_c;
      if (update_mask[UM_SF]) arith[SF_BIT] = sf_c;
      if (update_mask[UM_OF]) arith[OF_BIT] = overflow_in;
      case (ctl)
         CTL_CLC: arith[CF_BIT] = 1'b0;
         CTL_STC: arith[CF_BIT] = 1'b1;
         CTL_CMC: arith[CF_BIT] = ~flags[CF_BIT];
         CTL_CLI: arith[IF_BIT] = 1'b0;
         CTL_STI: arith[IF_BIT] = 1'b1;
         CTL_CLD: arith[DF_BIT] = 1'b0;
         CTL_STD: arith[DF_BIT] = 1'b1;
         default: ;
      endcase

      flags_nxt = (arith & FLAGS_WMASK) | FLAGS_RESET;
      if (pop_take)
         flags_nxt = (stack_top & FLAGS_WMASK) | FLAGS_RESET;
      else if (load_en)
         flags_nxt = (load_data & FLAGS_WMASK) | FLAGS_RESET;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flags <= FLAGS_RESET;
      else
         flags <= flags_nxt;
   end

   assign flags_out = flags;
   assign cf        = flags[CF_BIT];
   assign pf        = flags[PF_BIT];
   assign af        = flags[AF_BIT];
   assign zf        = flags[ZF_BIT];
   assign sf        = flags[SF_BIT];
   assign tf        = flags[TF_BIT];
   assign if_flag   = flags[IF_BIT];
   assign df        = flags[DF_BIT];
   assign of        = flags[OF_BIT];

endmodule

// File: tb/tb_status_flags_reg.sv
// Directed + randomized check of status_flags_reg against a flag-level model
// with a queue for the save stack; follows FLAGS_STACK_EN like the design.
module tb_status_flags_reg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
`ifdef FLAGS_STACK_EN
   localparam bit STK_ON = 1'b1;
`else
   localparam bit STK_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] alu_result;
   logic              byte_op, carry_in, aux_carry_in, overflow_in;
   logic [5:0]        update_mask;
   logic [2:0]        ctl_op;
   logic              load_en;
   logic [15:0]       load_data;
   logic              push, pop;
   logic [15:0]       flags_out;
   logic              cf, pf, af, zf, sf, tf, if_flag, df, of;
   logic [CNT_W-1:0]  stack_count;
   logic              stack_full, stack_empty, stack_err;

   int vectors     = 0;
   int miscompares = 0;

   logic m_cf, m_pf, m_af, m_zf, m_sf, m_tf, m_if, m_df, m_of, m_err;
   logic [15:0] m_stk[$];

   status_flags_reg #(.DATA_W(DATA_W), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .alu_result(alu_result), .byte_op(byte_op),
      .carry_in(carry_in), .aux_carry_in(aux_carry_in), .overflow_in(overflow_in),
      .update_mask(update_mask), .ctl_op(ctl_op), .load_en(load_en),
      .load_data(load_data), .push(push), .pop(pop), .flags_out(flags_out),
      .cf(cf), .pf(pf), .af(af), .zf(zf), .sf(sf), .tf(tf), .if_flag(if_flag),
      .df(df), .of(of), .stack_count(stack_count), .stack_full(stack_full),
      .stack_empty(stack_empty), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] m_word();
      return {4'hF, m_of, m_df, m_if, m_tf, m_sf, m_zf, 1'b0, m_af, 1'b0, m_pf, 1'b1, m_cf};
   endfunction

   function automatic void m_set(input logic [15:0] w);
      m_cf = w[0];  m_pf = w[2];  m_af = w[4];  m_zf = w[6];  m_sf = w[7];
      m_tf = w[8];  m_if = w[9];  m_df = w[10]; m_of = w[11];
   endfunction

   task automatic model_reset();
      m_set(16'h0000);
      m_err = 1'b0;
      m_stk.delete();
   endtask

   // Next state of the model from its current state and the driven inputs.
   task automatic model_step();
      logic [15:0] old;
      logic [7:0]  lo;
      logic        sel, do_pop, do_push;
      int          n;
      old     = m_word();
      n       = m_stk.size();
      do_pop  = STK_ON && pop && !push && n > 0;
      do_push = STK_ON && push && !pop && n < int'(DEPTH);
      m_err   = STK_ON && ((push && pop) || (push && n == int'(DEPTH)) || (pop && n == 0));
      if (do_pop) begin
         m_set(m_stk[n-1]);
         void'(m_stk.pop_back());
      end else if (load_en) begin
         m_set(load_data);
      end else begin
         sel = byte_op || (DATA_W == 8);
         lo  = alu_result[7:0];
         if (update_mask[0]) m_cf = carry_in;
         if (update_mask[1]) m_pf = ($countones(lo) % 2) == 0;
         if (update_mask[2]) m_af = aux_carry_in;
         if (update_mask[3]) m_zf = sel ? (lo == 8'h00) : (alu_result == '0);
         if (update_mask[4]) m_sf = sel ? lo[7] : alu_result[DATA_W-1];
         if (update_mask[5]) m_of = overflow_in;
         case (ctl_op)
            3'd1: m_cf = 1'b0;
            3'd2: m_cf = 1'b1;
            3'd3: m_cf = ~old[0];
            3'd4: m_if = 1'b0;
            3'd5: m_if = 1'b1;
            3'd6: m_df = 1'b0;
            3'd7: m_df = 1'b1;
            default: ;
         endcase
      end
      if (do_push) m_stk.push_back(old);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":flags"}, flags_out, m_word());
      chk({tag, ":taps"}, 16'({cf, pf, af, zf, sf, tf, if_flag, df, of}),
          16'({m_cf, m_pf, m_af, m_zf, m_sf, m_tf, m_if, m_df, m_of}));
      chk({tag, ":count"}, 16'(stack_count), 16'(m_stk.size()));
      chk({tag, ":status"}, 16'({stack_full, stack_empty, stack_err}),
          16'({STK_ON && m_stk.size() == int'(DEPTH), m_stk.size() == 0, m_err}));
   endtask

   task automatic idle();
      alu_result = '0; byte_op = 1'b0; carry_in = 1'b0; aux_carry_in = 1'b0;
      overflow_in = 1'b0; update_mask = '0; ctl_op = '0; load_en = 1'b0;
      load_data = '0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int r;
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      chk("reset_word", flags_out, 16'hF002);
      rst = 1'b0;
      step("idle");

      alu_result = 16'h8000; update_mask = 6'h3F; carry_in = 1'b1;
      step("arith16");
      chk("arith16_word", flags_out, 16'hF087);

      idle();
      byte_op = 1'b1; alu_result = 16'h1280; update_mask = 6'b011010;
      step("byteop");
      chk("byteop_sf_zf_pf_cf", 16'({sf, zf, pf, cf}), 16'h0009);

      idle();
      load_en = 1'b1; load_data = 16'hFFFF;
      step("load");
      chk("load_word", flags_out, 16'hFFD7);
      idle();
      ctl_op = 3'd1; update_mask = 6'h01; carry_in = 1'b1;
      step("clc_wins");
      chk("clc_cf", 16'(cf), 16'h0000);

      // Fill past capacity, each push carrying a fresh word via load.
      for (int i = 0; i < 5; i++) begin
         idle();
         push = 1'b1; load_en = 1'b1; load_data = 16'($urandom);
         step("push");
      end
      idle();
      step("after_push");
      for (int i = 0; i < 5; i++) begin
         idle();
         pop = 1'b1;
         step("pop");
      end
      idle();
      step("after_pop");

      push = 1'b1; load_en = 1'b1; load_data = 16'h0A55;
      step("push_one");
      idle();
      push = 1'b1; pop = 1'b1; ctl_op = 3'd5;
      step("push_pop_sti");
      chk("push_pop_if", 16'(if_flag), 16'h0001);

      // Asynchronous reset asserted between clock edges.
      idle();
      push = 1'b1;
      step("pre_async");
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      idle();
      step("post_async");

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 5);
         alu_result   = (r == 0) ? '0 : (r == 1) ? {8'($urandom), 8'h00} : DATA_W'($urandom);
         byte_op      = 1'($urandom);
         carry_in     = 1'($urandom);
         aux_carry_in = 1'($urandom);
         overflow_in  = 1'($urandom);
         update_mask  = 6'($urandom);
         ctl_op       = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
         load_en      = ($urandom_range(0, 7) == 0);
         load_data    = 16'($urandom);
         push         = ($urandom_range(0, 2) == 0);
         pop          = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
